// File: rtl/fetch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fetch_ctrl_pkg
// Shared types and constants for the instruction fetch controller.
//   fetch_state_t : controller FSM states
//   PC_SRC_SEQ    : PC mux select value meaning "sequential fetch"
//   is_redirect() : decodes the execute-stage PC mux select into a redirect flag
// -----------------------------------------------------------------------------
package fetch_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    WAIT    = 3'd2,
    HOLD    = 3'd3,
    DISCARD = 3'd4
  } fetch_state_t;

  localparam logic [1:0] PC_SRC_SEQ = 2'b00;

  // Any non-sequential PC source means execute has redirected the fetch stream.
  function automatic logic is_redirect(input logic [1:0] pc_src);
    return (pc_src != PC_SRC_SEQ);
  endfunction

endpackage

// File: rtl/dff_async_rst_en.sv
// -----------------------------------------------------------------------------
// dff_async_rst_en
// Enabled register with asynchronous active-high reset to zero.
// Used as the fetch hold buffer for an instruction returned while decode stalls.
//   clk : clock
//   rst : asynchronous active-high reset
//   en  : load enable
//   d   : data in
//   q   : registered data out
// -----------------------------------------------------------------------------
module dff_async_rst_en #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  // Storage register: load on enable, clear on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (en) begin
      r_q <= d;
    end else begin
      r_q <= r_q;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/fetch_controller.sv
// -----------------------------------------------------------------------------
// fetch_controller
// Sequences the fetch stage against a variable-latency handshaked instruction
// memory. One request is outstanding at most. Returned instructions go to the
// F/D register, are held while decode stalls, and responses made stale by an
// execute-stage redirect are drained and dropped.
//
// Ports:
//   clk            : clock, all state on rising edge
//   async_rst      : asynchronous active-high reset
//   PC_F           : current fetch PC
//   PC_source_E    : PC mux select, 2'b00 sequential, otherwise redirect
//   stall_D        : decode cannot accept an instruction this cycle
//   imem_req_valid : request valid
//   imem_req_ready : memory accepts request
//   imem_addr      : request address (PC_F)
//   imem_rsp_valid : one-cycle response pulse per accepted request
//   imem_rsp_data  : response instruction
//   instr_F        : instruction to F/D register
//   instr_valid_F  : instr_F valid this cycle
//   enable_fetch   : PC register load enable
//   flush_D        : clear F/D register at next edge
// All outputs are combinational from state and inputs.
// -----------------------------------------------------------------------------
module fetch_controller
  import fetch_ctrl_pkg::*;
#(
  parameter int PC_WIDTH    = 32,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   async_rst,
  input  logic [PC_WIDTH-1:0]    PC_F,
  input  logic [1:0]             PC_source_E,
  input  logic                   stall_D,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_rsp_valid,
  input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
  output logic [INSTR_WIDTH-1:0] instr_F,
  output logic                   instr_valid_F,
  output logic                   enable_fetch,
  output logic                   flush_D
);

  fetch_state_t           r_state;
  fetch_state_t           w_next_state;
  logic                   w_redirect;
  logic                   w_hold_en;
  logic [INSTR_WIDTH-1:0] w_hold_q;

  assign w_redirect = is_redirect(PC_source_E);

  // Hold buffer: captures a response that arrives while decode is stalled.
  dff_async_rst_en #(
    .WIDTH (INSTR_WIDTH)
  ) u_hold_buf (
    .clk (clk),
    .rst (async_rst),
    .en  (w_hold_en),
    .d   (imem_rsp_data),
    .q   (w_hold_q)
  );

  // State register.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and output decode.
  always_comb begin
    w_next_state   = r_state;
    w_hold_en      = 1'b0;
    imem_req_valid = 1'b0;
    imem_addr      = '0;
    instr_F        = '0;
    instr_valid_F  = 1'b0;
    enable_fetch   = 1'b0;
    flush_D        = 1'b0;

    case (r_state)
      IDLE: begin
        // Single post-reset cycle with all outputs quiet.
        w_next_state = REQ;
      end

      REQ: begin
        imem_req_valid = 1'b1;
        // Address tracks PC_F until accepted, so a redirect before acceptance
        // simply retargets the pending request.
        imem_addr      = PC_F;
        enable_fetch   = w_redirect;
        flush_D        = w_redirect;
        if (imem_req_ready) begin
          // Accepted in the redirect cycle: the address is the old PC, so its
          // response must be drained.
          w_next_state = w_redirect ? DISCARD : WAIT;
        end else begin
          w_next_state = REQ;
        end
      end

      WAIT: begin
        enable_fetch = w_redirect;
        flush_D      = w_redirect;
        if (imem_rsp_valid) begin
          if (w_redirect) begin
            w_next_state = REQ;
          end else begin
            instr_F       = imem_rsp_data;
            instr_valid_F = 1'b1;
            if (stall_D) begin
              w_hold_en    = 1'b1;
              w_next_state = HOLD;
            end else begin
              enable_fetch = 1'b1;
              w_next_state = REQ;
            end
          end
        end else if (w_redirect) begin
          w_next_state = DISCARD;
        end else begin
          w_next_state = WAIT;
        end
      end

      HOLD: begin
        enable_fetch = w_redirect;
        flush_D      = w_redirect;
        if (w_redirect) begin
          w_next_state = REQ;
        end else begin
          instr_F       = w_hold_q;
          instr_valid_F = 1'b1;
          if (!stall_D) begin
            enable_fetch = 1'b1;
            w_next_state = REQ;
          end else begin
            w_next_state = HOLD;
          end
        end
      end

      DISCARD: begin
        // Repeated redirects still move the PC; the stale response is dropped.
        enable_fetch = w_redirect;
        flush_D      = w_redirect;
        if (imem_rsp_valid) begin
          w_next_state = REQ;
        end else begin
          w_next_state = DISCARD;
        end
      end

      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_controller.sv
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        async_rst;
  logic [31:0] PC_F;
  logic [1:0]  PC_source_E;
  logic        stall_D;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] instr_F;
  logic        instr_valid_F;
  logic        enable_fetch;
  logic        flush_D;

  always #5 clk = ~clk;

  fetch_controller #(.PC_WIDTH(32), .INSTR_WIDTH(32)) dut (
    .clk            (clk),
    .async_rst      (async_rst),
    .PC_F           (PC_F),
    .PC_source_E    (PC_source_E),
    .stall_D        (stall_D),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_F        (instr_F),
    .instr_valid_F  (instr_valid_F),
    .enable_fetch   (enable_fetch),
    .flush_D        (flush_D)
  );

  int checks = 0;
  int errors = 0;

  // Transaction-level reference: what the fetch unit is currently waiting on.
  bit          m_idle;       // first cycle after reset
  bit          m_busy;       // a request has been accepted, response pending
  bit          m_stale;      // the pending response belongs to a redirected-away PC
  bit          m_held;       // an instruction is waiting for decode
  logic [31:0] m_held_data;

  // Memory model
  bit          mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr;
  int          lat_cfg;
  bit          fixed_mode;
  logic [31:0] fixed_data;

  logic [31:0] pc;

  logic        e_req, e_valid, e_en, e_flush;
  logic [31:0] e_addr, e_instr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[31:16]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compute_expected(input logic [1:0] src, input bit stall,
                                  input bit rsp_v, input logic [31:0] rsp_d);
    bit redir;
    redir   = (src != 2'b00);
    e_req   = 1'b0; e_valid = 1'b0; e_en = 1'b0; e_flush = 1'b0;
    e_addr  = 32'd0; e_instr = 32'd0;
    if (m_idle) begin
      // all quiet
    end else if (m_held) begin
      e_valid = !redir;
      e_instr = m_held_data;
      e_en    = redir | !stall;
      e_flush = redir;
    end else if (m_busy) begin
      if (rsp_v && !m_stale && !redir) begin
        e_valid = 1'b1;
        e_instr = rsp_d;
      end
      e_en    = redir | (e_valid & !stall);
      e_flush = redir;
    end else begin
      e_req   = 1'b1;
      e_addr  = pc;
      e_en    = redir;
      e_flush = redir;
    end
  endtask

  task automatic check_outputs();
    check("req_valid", {31'd0, imem_req_valid}, {31'd0, e_req});
    if (e_req) check("imem_addr", imem_addr, e_addr);
    check("instr_valid_F", {31'd0, instr_valid_F}, {31'd0, e_valid});
    if (e_valid) check("instr_F", instr_F, e_instr);
    check("enable_fetch", {31'd0, enable_fetch}, {31'd0, e_en});
    check("flush_D", {31'd0, flush_D}, {31'd0, e_flush});
  endtask

  task automatic step(input logic [1:0] src, input bit stall, input bit rdy, input logic [31:0] tgt);
    bit          rsp_v;
    bit          redir;
    logic [31:0] rsp_d;
    @(negedge clk);
    rsp_v          = mem_busy && (mem_cnt == 0);
    rsp_d          = fixed_mode ? fixed_data : mem_word(mem_addr);
    PC_F           = pc;
    PC_source_E    = src;
    stall_D        = stall;
    imem_req_ready = rdy;
    imem_rsp_valid = rsp_v;
    imem_rsp_data  = rsp_v ? rsp_d : 32'hDEAD_BEEF;
    #1;
    compute_expected(src, stall, rsp_v, rsp_d);
    check_outputs();
    @(posedge clk);
    redir = (src != 2'b00);
    if (rsp_v) mem_busy = 1'b0;
    else if (mem_busy) mem_cnt--;
    if (e_req && rdy) begin
      mem_busy = 1'b1;
      mem_cnt  = lat_cfg;
      mem_addr = pc;
    end
    if (e_en) pc = redir ? tgt : pc + 32'd4;
    if (m_idle) begin
      m_idle = 1'b0;
    end else if (m_held) begin
      if (redir || !stall) m_held = 1'b0;
    end else if (m_busy) begin
      if (rsp_v) begin
        m_busy = 1'b0;
        if (!m_stale && !redir && stall) begin
          m_held      = 1'b1;
          m_held_data = rsp_d;
        end
        m_stale = 1'b0;
      end else if (redir) begin
        m_stale = 1'b1;
      end
    end else if (rdy) begin
      m_busy  = 1'b1;
      m_stale = redir;
    end
  endtask

  // Advance with plain fetching until the memory will respond in the next step.
  task automatic wait_rsp();
    bit found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (mem_busy && mem_cnt == 0) begin
        found = 1'b1;
        break;
      end
      step(2'b00, 1'b0, 1'b1, 32'd0);
    end
    checks++;
    assert (found) else begin
      errors++;
      $error("FAIL wait_rsp observed=timeout expected=response");
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    async_rst      = 1'b1;
    PC_source_E    = 2'b00;
    imem_rsp_valid = 1'b0;
    #1;
    m_idle = 1'b1; m_busy = 1'b0; m_stale = 1'b0; m_held = 1'b0;
    mem_busy = 1'b0; mem_cnt = 0;
    compute_expected(2'b00, 1'b0, 1'b0, 32'd0);
    check("rst_instr_F", instr_F, 32'd0);
    check_outputs();
    @(posedge clk);
    #1 async_rst = 1'b0;
  endtask

  initial begin
    async_rst = 1'b1; PC_F = 32'd0; PC_source_E = 2'b00; stall_D = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0;
    pc = 32'h0000_1000; lat_cfg = 0; fixed_mode = 1'b1; fixed_data = 32'h0000_0013;
    m_held_data = 32'd0; mem_addr = 32'd0; mem_cnt = 0;

    // Reset then zero-wait memory returning a fixed NOP.
    apply_reset();
    for (int i = 0; i < 10; i++) step(2'b00, 1'b0, 1'b1, 32'd0);

    // Response arriving during a 3-cycle decode stall.
    fixed_data = 32'h00A0_0093;
    wait_rsp();
    for (int i = 0; i < 3; i++) step(2'b00, 1'b1, 1'b1, 32'd0);
    step(2'b00, 1'b0, 1'b1, 32'd0);
    step(2'b00, 1'b0, 1'b1, 32'd0);

    // Redirect while waiting on a 4-cycle memory latency.
    fixed_mode = 1'b0; lat_cfg = 3;
    for (int i = 0; i < 10 && !(m_busy && mem_cnt >= 1); i++) step(2'b00, 1'b0, 1'b1, 32'd0);
    step(2'b10, 1'b0, 1'b1, 32'h0000_4000);
    for (int i = 0; i < 10; i++) step(2'b00, 1'b0, 1'b1, 32'd0);

    // Redirect coinciding with a response and a decode stall.
    lat_cfg = 0;
    wait_rsp();
    step(2'b01, 1'b1, 1'b1, 32'h0000_8000);
    for (int i = 0; i < 4; i++) step(2'b00, 1'b0, 1'b1, 32'd0);

    // Memory not ready for 5 cycles with a redirect in the 2nd.
    for (int i = 0; i < 10 && (m_busy || m_held || m_idle); i++) step(2'b00, 1'b0, 1'b1, 32'd0);
    step(2'b00, 1'b0, 1'b0, 32'd0);
    step(2'b11, 1'b0, 1'b0, 32'h0000_C000);
    for (int i = 0; i < 3; i++) step(2'b00, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 6; i++) step(2'b00, 1'b0, 1'b1, 32'd0);

    // Reset asserted while a request is in flight.
    lat_cfg = 3;
    for (int i = 0; i < 10 && !m_busy; i++) step(2'b00, 1'b0, 1'b1, 32'd0);
    apply_reset();
    for (int i = 0; i < 8; i++) step(2'b00, 1'b0, 1'b1, 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      logic [1:0]  src;
      logic [31:0] tgt;
      src     = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      tgt     = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      tgt     = tgt & 32'h0000_FFFC;
      lat_cfg = $urandom_range(0, 3);
      step(src, ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 1), tgt);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
